// File: rtl/vga_tile_renderer.sv
// vga_tile_renderer: tile playfield renderer with ping-pong tagged row buffers, age-shaded body, flash border and blinking apple.
module vga_tile_renderer #(
  parameter int GAME_WIDTH   = 18,
  parameter int GAME_HEIGHT  = 13,
  parameter int TILE_SHIFT   = 5,
  parameter int COLOR_BITS   = 2,
  parameter int AGE_BITS     = 4,
  parameter int FLASH_FRAMES = 8,
  parameter int BLINK_SHIFT  = 4,
  localparam int XW = $clog2(GAME_WIDTH + 2),
  localparam int YW = $clog2(GAME_HEIGHT + 2)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  visible_i,
  input  logic [9:0]            px_i,
  input  logic [9:0]            py_i,
  input  logic                  hsync_i,
  input  logic                  vsync_i,
  input  logic [XW-1:0]         head_x_i,
  input  logic [YW-1:0]         head_y_i,
  input  logic [XW-1:0]         apple_x_i,
  input  logic [YW-1:0]         apple_y_i,
  input  logic                  apple_valid_i,
  input  logic [XW-1:0]         seg_x_i,
  input  logic [YW-1:0]         seg_y_i,
  input  logic                  seg_first_i,
  input  logic                  seg_valid_i,
  input  logic                  failure_i,
  input  logic                  success_i,
  input  logic                  eat_i,
  input  logic                  colorblind_i,
  output logic [COLOR_BITS-1:0] r_o,
  output logic [COLOR_BITS-1:0] g_o,
  output logic [COLOR_BITS-1:0] b_o,
  output logic                  hsync_o,
  output logic                  vsync_o
);
  localparam int FW  = $clog2(FLASH_FRAMES + 1);
  localparam int FCW = BLINK_SHIFT + 1;
  localparam logic [XW-1:0] XLAST = XW'(GAME_WIDTH);
  localparam logic [XW-1:0] XMAX  = XW'(GAME_WIDTH + 1);
  localparam logic [YW-1:0] YMAX  = YW'(GAME_HEIGHT + 1);
  localparam logic [COLOR_BITS-1:0] CM = '1;

  typedef struct packed {
    logic                v;
    logic [YW-1:0]       tag;
    logic [AGE_BITS-1:0] age;
  } ent_t;

  ent_t                bank_q [2][GAME_WIDTH];
  logic                sel_q, sel_d;
  logic [YW-1:0]       ty_line_q, ty_line_d;
  logic [AGE_BITS-1:0] seg_idx_q, seg_idx_d, cur_idx;
  logic [FW-1:0]       flash_q, flash_d;
  logic [FCW-1:0]      frame_q, frame_d;
  logic [COLOR_BITS-1:0] r_q, g_q, b_q, r_d, g_d, b_d, gp, bp, sh, lvl;
  logic                hs_q, vs_q;
  logic [XW-1:0]       tx, rx, wx;
  logic [YW-1:0]       ty;
  logic [YW:0]         ty_nx;
  logic                line_start, frame_start, cap, in_x, in_area, border, head_hit, apple_hit, body;
  ent_t                rd;

  assign tx          = XW'(px_i >> TILE_SHIFT);
  assign ty          = YW'(py_i >> TILE_SHIFT);
  assign ty_nx       = {1'b0, ty} + 1'b1;
  assign line_start  = px_i == '0;
  assign frame_start = line_start && py_i == '0;

  // Bank swap only when the tile row changes, so captures for the next row land in the hidden bank
  assign sel_d     = (line_start && ty != ty_line_q) ? ~sel_q : sel_q;
  assign ty_line_d = line_start ? ty : ty_line_q;

  assign cur_idx   = seg_first_i ? '0 : seg_idx_q;
  assign seg_idx_d = (seg_valid_i && cur_idx != '1) ? cur_idx + 1'b1 : cur_idx;
  assign cap       = seg_valid_i && {1'b0, seg_y_i} == ty_nx && seg_x_i != '0 && seg_x_i <= XLAST;
  assign wx        = seg_x_i - 1'b1;

  assign flash_d = eat_i ? FW'(FLASH_FRAMES) : (frame_start && flash_q != '0) ? flash_q - 1'b1 : flash_q;
  assign frame_d = frame_start ? frame_q + 1'b1 : frame_q;

  assign in_x      = tx != '0 && tx <= XLAST;
  assign rx        = in_x ? tx - 1'b1 : '0;
  assign rd        = bank_q[sel_q][rx];
  assign in_area   = tx <= XMAX && ty <= YMAX;
  assign border    = tx == '0 || tx == XMAX || ty == '0 || ty == YMAX;
  assign head_hit  = tx == head_x_i && ty == head_y_i;
  assign apple_hit = apple_valid_i && tx == apple_x_i && ty == apple_y_i;
  // Stale entries from earlier rows fail the tag match and read as background
  assign body      = in_x && rd.v && rd.tag == ty;
  assign sh        = rd.age[AGE_BITS-1 -: COLOR_BITS];
  assign lvl       = (sh == CM) ? COLOR_BITS'(1) : CM - sh;

  always_comb begin
    r_d = '0;
    gp  = '0;
    bp  = '0;
    if (visible_i && in_area) begin
      if (head_hit && !failure_i) begin
        r_d = CM;
        gp  = CM >> 1;
      end else if (border) begin
        r_d = success_i ? '0 : CM;
        gp  = (success_i || !failure_i) ? CM : '0;
        bp  = (!success_i && !failure_i && flash_q == '0) ? CM : '0;
      end else if (apple_hit) begin
        r_d = (failure_i && frame_q[BLINK_SHIFT]) ? '0 : CM;
      end else if (body) begin
        gp  = lvl;
      end
    end
  end

  assign g_d = colorblind_i ? bp : gp;
  assign b_d = colorblind_i ? gp : bp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q     <= 1'b0;
      ty_line_q <= '0;
      seg_idx_q <= '0;
      flash_q   <= '0;
      frame_q   <= '0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
    end else begin
      sel_q     <= sel_d;
      ty_line_q <= ty_line_d;
      seg_idx_q <= seg_idx_d;
      flash_q   <= flash_d;
      frame_q   <= frame_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      hs_q      <= hsync_i;
      vs_q      <= vsync_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < GAME_WIDTH; i++) begin
        bank_q[0][i] <= '0;
        bank_q[1][i] <= '0;
      end
    end else if (cap) begin
      bank_q[~sel_q][wx] <= '{v: 1'b1, tag: seg_y_i, age: cur_idx};
    end
  end

  assign r_o     = r_q;
  assign g_o     = g_q;
  assign b_o     = b_q;
  assign hsync_o = hs_q;
  assign vsync_o = vs_q;
endmodule

// File: tb/tb_vga_tile_renderer.sv
// tb_vga_tile_renderer: directed vector table plus hand sequences for reset, capture, flash and blink.
module tb_vga_tile_renderer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       visible = 1'b0;
  logic [9:0] px = '0, py = '0;
  logic       hsync_in = 1'b1, vsync_in = 1'b1;
  logic [4:0] head_x = 5'd10, apple_x = 5'd15, seg_x = '0;
  logic [3:0] head_y = 4'd10, apple_y = 4'd10, seg_y = '0;
  logic       apple_valid = 1'b1, seg_first = 1'b0, seg_valid = 1'b0;
  logic       failure = 1'b0, success = 1'b0, eat = 1'b0, colorblind = 1'b0;
  logic [1:0] r, g, b;
  logic       hsync, vsync;
  int         checks = 0, errors = 0, fc = 0;

  always #5 clk = ~clk;

  vga_tile_renderer dut (
    .clk(clk), .rst(rst), .visible_i(visible), .px_i(px), .py_i(py),
    .hsync_i(hsync_in), .vsync_i(vsync_in), .head_x_i(head_x), .head_y_i(head_y),
    .apple_x_i(apple_x), .apple_y_i(apple_y), .apple_valid_i(apple_valid),
    .seg_x_i(seg_x), .seg_y_i(seg_y), .seg_first_i(seg_first), .seg_valid_i(seg_valid),
    .failure_i(failure), .success_i(success), .eat_i(eat), .colorblind_i(colorblind),
    .r_o(r), .g_o(g), .b_o(b), .hsync_o(hsync), .vsync_o(vsync)
  );

  typedef struct {
    string nm;
    int    x, y;
    bit    vis, fail, succ, cb;
    int    er, eg, eb;
  } vec_t;

  vec_t tbl [26];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int er, input int eg, input int eb);
    checks++;
    if (r !== 2'(er) || g !== 2'(eg) || b !== 2'(eb)) begin
      errors++;
      $display("FAIL %s: got r=%0d g=%0d b=%0d, want r=%0d g=%0d b=%0d", nm, r, g, b, er, eg, eb);
    end
  endtask

  task automatic chk_sync(input string nm, input logic eh, input logic ev);
    checks++;
    if (hsync !== eh || vsync !== ev) begin
      errors++;
      $display("FAIL %s: got hsync=%b vsync=%b, want hsync=%b vsync=%b", nm, hsync, vsync, eh, ev);
    end
  endtask

  task automatic pix(input int x, input int y);
    px = 10'(x);
    py = 10'(y);
    tick();
  endtask

  task automatic frame();
    pix(0, 0);
    fc++;
  endtask

  task automatic seg(input int x, input int y, input bit first);
    seg_x = 5'(x);
    seg_y = 4'(y);
    seg_first = first;
    seg_valid = 1'b1;
    tick();
    seg_valid = 1'b0;
    seg_first = 1'b0;
  endtask

  task automatic border_chk(input string nm, input bit yellow);
    pix(5, 40);
    chk(nm, 3, 3, yellow ? 0 : 3);
  endtask

  initial begin
    tbl[0]  = '{"body_t4_age0",   133, 168, 1, 0, 0, 0, 0, 3, 0};
    tbl[1]  = '{"body_t5_age1",   165, 168, 1, 0, 0, 0, 0, 3, 0};
    tbl[2]  = '{"body_t6_age2",   197, 168, 1, 0, 0, 0, 0, 3, 0};
    tbl[3]  = '{"body_t7_age3",   229, 168, 1, 0, 0, 0, 0, 3, 0};
    tbl[4]  = '{"body_t8_age4",   261, 168, 1, 0, 0, 0, 0, 2, 0};
    tbl[5]  = '{"body_t11_age7",  357, 168, 1, 0, 0, 0, 0, 2, 0};
    tbl[6]  = '{"empty_t12",      389, 168, 1, 0, 0, 0, 0, 0, 0};
    tbl[7]  = '{"wrong_row_seg",  421, 168, 1, 0, 0, 0, 0, 0, 0};
    tbl[8]  = '{"not_visible",    133, 168, 0, 0, 0, 0, 0, 0, 0};
    tbl[9]  = '{"body_cb",        133, 168, 1, 0, 0, 1, 0, 0, 3};
    tbl[10] = '{"left_border",      5, 168, 1, 0, 0, 0, 3, 3, 3};
    tbl[11] = '{"right_border",   613, 168, 1, 0, 0, 0, 3, 3, 3};
    tbl[12] = '{"outside_x",      645, 168, 1, 0, 0, 0, 0, 0, 0};
    tbl[13] = '{"row7_t13",       421, 232, 1, 0, 0, 0, 0, 0, 0};
    tbl[14] = '{"row7_t4_stale",  133, 232, 1, 0, 0, 0, 0, 0, 0};
    tbl[15] = '{"head",           325, 328, 1, 0, 0, 0, 3, 1, 0};
    tbl[16] = '{"head_failure",   325, 328, 1, 1, 0, 0, 0, 0, 0};
    tbl[17] = '{"apple",          485, 328, 1, 0, 0, 0, 3, 0, 0};
    tbl[18] = '{"apple_fail_f0",  485, 328, 1, 1, 0, 0, 3, 0, 0};
    tbl[19] = '{"top_border",     101,   8, 1, 0, 0, 0, 3, 3, 3};
    tbl[20] = '{"bottom_border",  101, 456, 1, 0, 0, 0, 3, 3, 3};
    tbl[21] = '{"outside_y",      101, 488, 1, 0, 0, 0, 0, 0, 0};
    tbl[22] = '{"border_failure",   5, 168, 1, 1, 0, 0, 3, 0, 0};
    tbl[23] = '{"border_success",   5, 168, 1, 0, 1, 0, 0, 3, 0};
    tbl[24] = '{"border_succ_cb",   5, 168, 1, 0, 1, 1, 0, 0, 3};
    tbl[25] = '{"body_failure",   133, 168, 1, 1, 0, 0, 0, 3, 0};

    // Reset asserted mid-line after a lit pixel
    px = 10'd5;
    py = 10'd40;
    visible = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    tick();
    chk("pre_reset_white", 3, 3, 3);
    chk_sync("pre_reset_sync", 1'b0, 1'b0);
    #3 rst = 1'b1;
    #1;
    chk("async_reset_rgb", 0, 0, 0);
    chk_sync("async_reset_sync", 1'b1, 1'b1);
    tick();
    rst = 1'b0;
    tick();
    chk_sync("sync_delay_low", 1'b0, 1'b0);
    hsync_in = 1'b1;
    tick();
    chk_sync("sync_delay_high", 1'b1, 1'b0);
    vsync_in = 1'b1;

    // Capture row 5 during tile row 4, then move to row 5
    pix(0, 128);
    px = 10'd100;
    seg(4, 5, 1'b1);
    for (int x = 5; x <= 11; x++) seg(x, 5, 1'b0);
    seg(13, 7, 1'b0);
    seg(0, 5, 1'b0);
    seg(19, 5, 1'b0);
    pix(0, 160);

    for (int i = 0; i < 26; i++) begin
      visible = tbl[i].vis;
      failure = tbl[i].fail;
      success = tbl[i].succ;
      colorblind = tbl[i].cb;
      pix(tbl[i].x, tbl[i].y);
      chk(tbl[i].nm, tbl[i].er, tbl[i].eg, tbl[i].eb);
    end
    visible = 1'b1;
    failure = 1'b0;
    success = 1'b0;
    colorblind = 1'b0;
    apple_valid = 1'b0;
    pix(485, 328);
    chk("apple_invalid", 0, 0, 0);
    apple_valid = 1'b1;

    // Eat flash lasts exactly FLASH_FRAMES frame starts
    eat = 1'b1;
    pix(5, 40);
    eat = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      border_chk($sformatf("flash_a_%0d", k), k < 8);
      if (k < 8) frame();
    end

    // Eat coinciding with frame start: load beats decrement
    eat = 1'b1;
    frame();
    eat = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      frame();
      border_chk($sformatf("flash_b_%0d", k), k < 8);
    end

    // Second eat mid-flash reloads the full count
    eat = 1'b1;
    pix(5, 40);
    eat = 1'b0;
    repeat (3) frame();
    border_chk("flash_c_mid", 1'b1);
    eat = 1'b1;
    pix(5, 40);
    eat = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      frame();
      border_chk($sformatf("flash_c_%0d", k), k < 8);
    end

    // Apple blinks on game over; head suppressed
    failure = 1'b1;
    apple_x = 5'd3;
    apple_y = 4'd3;
    head_x = 5'd5;
    head_y = 4'd3;
    for (int i = 0; i < 40; i++) begin
      pix(100, 100);
      chk($sformatf("blink_f%0d", fc), ((fc / 16) % 2) ? 0 : 3, 0, 0);
      if (i % 8 == 0) begin
        pix(164, 100);
        chk("blink_head_hidden", 0, 0, 0);
      end
      frame();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
